// File: rtl/hash_round_sequencer.sv
// hash_round_sequencer: control FSM for a round-based compression core.
// Turns enable/soft-reset into init/load/round/update strobes; chains blocks.
module hash_round_sequencer #(
  parameter int unsigned NumRounds   = 64,
  parameter int unsigned CntWidth    = $clog2(NumRounds),
  parameter int unsigned BlockWidth  = 512,
  parameter int unsigned BlkCntWidth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   reset_i,
  input  logic [BlockWidth-1:0]  block_i,
  output logic                   idle_o,
  output logic                   hold_o,
  output logic                   digest_valid_o,
  output logic                   core_init_o,
  output logic                   core_load_o,
  output logic                   core_round_o,
  output logic [CntWidth-1:0]    round_idx_o,
  output logic                   core_update_o,
  output logic [BlockWidth-1:0]  block_o,
  output logic [BlkCntWidth-1:0] blk_count_o,
  output logic                   start_drop_o
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StInit   = 3'd1;
  localparam logic [2:0] StLoad   = 3'd2;
  localparam logic [2:0] StRound  = 3'd3;
  localparam logic [2:0] StUpdate = 3'd4;
  localparam logic [2:0] StHold   = 3'd5;

  localparam logic [CntWidth-1:0] LastIdx =
    CntWidth'(NumRounds - 1);
  localparam logic [BlkCntWidth-1:0] BlkMax = '1;

  logic [2:0]             state_q, state_d;
  logic [CntWidth-1:0]    idx_q, idx_d;
  logic [BlockWidth-1:0]  block_q, block_d;
  logic [BlkCntWidth-1:0] cnt_q, cnt_d;
  logic                   drop_q, drop_d;
  logic                   en_q;
  logic                   start;
  logic                   busy;

  assign start = enable_i & ~en_q;
  assign busy  = (state_q == StInit) | (state_q == StLoad) |
                 (state_q == StRound) | (state_q == StUpdate);

  // Next-state logic; soft reset overrides everything, block snapshot kept.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    block_d = block_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    if (reset_i) begin
      state_d = StIdle;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      drop_d = start & busy;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StInit;
            block_d = block_i;
          end
        end
        StInit: state_d = StLoad;
        StLoad: begin
          state_d = StRound;
          idx_d   = '0;
        end
        StRound: begin
          if (idx_q == LastIdx) begin
            state_d = StUpdate;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CntWidth'(1);
          end
        end
        StUpdate: begin
          state_d = StHold;
          if (cnt_q != BlkMax) begin
            cnt_d = cnt_q + BlkCntWidth'(1);
          end
        end
        StHold: begin
          if (start) begin
            state_d = StLoad;
            block_d = block_i;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, counters, snapshot and enable edge register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      block_q <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      block_q <= block_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      en_q    <= enable_i;
    end
  end

  assign idle_o         = (state_q == StIdle);
  assign hold_o         = (state_q == StHold);
  assign digest_valid_o = (state_q == StHold);
  assign core_init_o    = (state_q == StInit);
  assign core_load_o    = (state_q == StLoad);
  assign core_round_o   = (state_q == StRound);
  assign core_update_o  = (state_q == StUpdate);
  assign round_idx_o    = idx_q;
  assign block_o        = block_q;
  assign blk_count_o    = cnt_q;
  assign start_drop_o   = drop_q;

endmodule

// File: tb/tb_hash_round_sequencer.sv
// tb_hash_round_sequencer: directed checks of the round sequencer.
// Second instance uses tiny counters to exercise saturation.
module tb_hash_round_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, srst;
  logic [511:0] blk_in;
  logic         idle, hold, dv, init, load, rnd, upd, drop;
  logic [5:0]   idx;
  logic [511:0] blk_o;
  logic [15:0]  cnt;

  logic         en2, srst2;
  logic [7:0]   blk2_in;
  logic         idle2, hold2, dv2, init2, load2, rnd2, upd2, drop2;
  logic [0:0]   idx2;
  logic [7:0]   blk2_o;
  logic [1:0]   cnt2;

  int checks = 0;
  int errors = 0;

  logic [511:0] blk_a, blk_b, blk_c, blk_d, blk_e;

  hash_round_sequencer dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .reset_i(srst),
    .block_i(blk_in), .idle_o(idle), .hold_o(hold),
    .digest_valid_o(dv), .core_init_o(init), .core_load_o(load),
    .core_round_o(rnd), .round_idx_o(idx), .core_update_o(upd),
    .block_o(blk_o), .blk_count_o(cnt), .start_drop_o(drop)
  );

  hash_round_sequencer #(
    .NumRounds(2), .BlockWidth(8), .BlkCntWidth(2)
  ) dut2 (
    .clk_i(clk), .rst_i(rst), .enable_i(en2), .reset_i(srst2),
    .block_i(blk2_in), .idle_o(idle2), .hold_o(hold2),
    .digest_valid_o(dv2), .core_init_o(init2), .core_load_o(load2),
    .core_round_o(rnd2), .round_idx_o(idx2), .core_update_o(upd2),
    .block_o(blk2_o), .blk_count_o(cnt2), .start_drop_o(drop2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_st(input string tag, input logic [3:0] str,
                        input logic ei, input logic eh,
                        input logic ed);
    chk({tag, "_strb"}, {60'd0, init, load, rnd, upd}, {60'd0, str});
    chk({tag, "_idle"}, {63'd0, idle}, {63'd0, ei});
    chk({tag, "_hold"}, {63'd0, hold}, {63'd0, eh});
    chk({tag, "_dv"}, {63'd0, dv}, {63'd0, ed});
  endtask

  task automatic chk_blk(input string tag, input logic [511:0] e);
    chk({tag, "_lo"}, blk_o[63:0], e[63:0]);
    chk({tag, "_hi"}, blk_o[511:448], e[511:448]);
  endtask

  task automatic run_rounds(input string tag);
    for (int i = 0; i < 64; i++) begin
      step();
      chk_st(tag, 4'b0010, 1'b0, 1'b0, 1'b0);
      chk({tag, "_idx"}, {58'd0, idx}, i);
    end
  endtask

  initial begin
    blk_a = {32'h61626380, 416'd0, 64'h18};
    blk_b = {8{64'h0123_4567_89ab_cdef}};
    blk_c = ~blk_b;
    blk_d = {8{64'hdead_beef_0000_0001}};
    blk_e = {8{64'h0000_0000_0000_5555}};
    rst = 1'b1; en = 1'b0; srst = 1'b0; blk_in = '0;
    en2 = 1'b0; srst2 = 1'b0; blk2_in = '0;
    step(); step();
    rst = 1'b0;

    // T1: idle after reset
    for (int i = 0; i < 10; i++) begin
      step();
      chk_st("t1", 4'b0000, 1'b1, 1'b0, 1'b0);
      chk("t1_cnt", {48'd0, cnt}, 0);
      chk("t1_idx", {58'd0, idx}, 0);
      chk("t1_drop", {63'd0, drop}, 0);
    end
    chk_blk("t1_blk", 512'd0);

    // T2: first block from IDLE
    blk_in = blk_a; en = 1'b1;
    step();
    chk_st("t2_init", 4'b1000, 1'b0, 1'b0, 1'b0);
    chk_blk("t2_blk", blk_a);
    step();
    chk_st("t2_load", 4'b0100, 1'b0, 1'b0, 1'b0);
    chk("t2_lidx", {58'd0, idx}, 0);
    run_rounds("t2_rnd");
    step();
    chk_st("t2_upd", 4'b0001, 1'b0, 1'b0, 1'b0);
    chk("t2_ucnt", {48'd0, cnt}, 0);
    step();
    chk_st("t2_hold", 4'b0000, 1'b0, 1'b1, 1'b1);
    chk("t2_cnt", {48'd0, cnt}, 1);
    chk_blk("t2_hblk", blk_a);

    // T3: chained block from HOLD, no init
    en = 1'b0;
    step();
    chk_st("t3_wait", 4'b0000, 1'b0, 1'b1, 1'b1);
    blk_in = blk_b; en = 1'b1;
    step();
    chk_st("t3_load", 4'b0100, 1'b0, 1'b0, 1'b0);
    chk_blk("t3_blk", blk_b);
    run_rounds("t3_rnd");
    step();
    chk_st("t3_upd", 4'b0001, 1'b0, 1'b0, 1'b0);
    step();
    chk_st("t3_hold", 4'b0000, 1'b0, 1'b1, 1'b1);
    chk("t3_cnt", {48'd0, cnt}, 2);

    // T4: level enable is not a start; start mid-round is dropped
    for (int i = 0; i < 3; i++) begin
      step();
      chk_st("t4_lvl", 4'b0000, 1'b0, 1'b1, 1'b1);
    end
    en = 1'b0;
    step();
    blk_in = blk_c; en = 1'b1;
    step();
    chk_st("t4_load", 4'b0100, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      step();
      chk_st("t4_rnd", 4'b0010, 1'b0, 1'b0, 1'b0);
      chk("t4_idx", {58'd0, idx}, i);
      chk("t4_drop", {63'd0, drop}, {63'd0, (i == 11)});
      if (i == 9) en = 1'b0;
      if (i == 10) begin
        en = 1'b1;
        blk_in = blk_d;
      end
    end
    chk_blk("t4_blk", blk_c);
    step();
    chk_st("t4_upd", 4'b0001, 1'b0, 1'b0, 1'b0);
    step();
    chk_st("t4_hold", 4'b0000, 1'b0, 1'b1, 1'b1);
    chk("t4_cnt", {48'd0, cnt}, 3);
    chk("t4_drop0", {63'd0, drop}, 0);

    // T5: soft reset mid-round, then reset+start together
    en = 1'b0;
    step();
    blk_in = blk_e; en = 1'b1;
    step();
    chk_st("t5_load", 4'b0100, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= 30; i++) begin
      step();
      chk("t5_idx", {58'd0, idx}, i);
    end
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk_st("t5_abort", 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("t5_cnt", {48'd0, cnt}, 0);
    chk("t5_idx0", {58'd0, idx}, 0);
    chk_blk("t5_blk", blk_e);
    step();
    chk_st("t5_after", 4'b0000, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    step();
    en = 1'b1; srst = 1'b1; blk_in = blk_a;
    step();
    srst = 1'b0;
    chk_st("t5_rs", 4'b0000, 1'b1, 1'b0, 1'b0);
    step();
    chk_st("t5_rs2", 4'b0000, 1'b1, 1'b0, 1'b0);
    step();
    chk_st("t5_rs3", 4'b0000, 1'b1, 1'b0, 1'b0);
    chk_blk("t5_rsblk", blk_e);
    chk("t5_drop", {63'd0, drop}, 0);

    // T6: saturation with a 2-bit block counter and 2 rounds
    chk("t6_idle", {63'd0, idle2}, 1);
    for (int b = 0; b < 5; b++) begin
      int n;
      en2 = 1'b0;
      step();
      blk2_in = 8'(b + 1); en2 = 1'b1;
      step();
      n = 1;
      while (!hold2 && n < 20) begin
        step();
        n++;
      end
      chk("t6_hold", {63'd0, hold2}, 1);
      chk("t6_cnt", {62'd0, cnt2}, (b + 1 > 3) ? 3 : b + 1);
      chk("t6_blk", {56'd0, blk2_o}, b + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
